// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - two-requester round-robin front end for one shared 4x4 array multiplier
module mult_share_arbiter #(
    parameter int WIDTH       = 4,
    parameter int CALC_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [2*WIDTH-1:0]   rsp0_p,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [2*WIDTH-1:0]   rsp1_p,
    output logic                 busy,
    output logic [7:0]           done_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] CALC_LAST = 2'(CALC_CYCLES - 1);

    logic [1:0]           state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic                 owner_q, owner_d;
    logic [1:0]           calc_cnt_q, calc_cnt_d;
    logic [7:0]           done_cnt_q, done_cnt_d;

    logic                 grant;
    logic [2*WIDTH-1:0]   mul_p;
    logic                 rsp_hs;

    // Array multiplier: AND-row partial products folded in by ripple rows of full adders
    always_comb begin
        logic [2*WIDTH-1:0] acc;
        logic [2*WIDTH-1:0] row;
        logic               c;
        logic               t;
        logic               nc;
        acc = {{WIDTH{1'b0}}, op_a_q & {WIDTH{op_b_q[0]}}};
        row = '0;
        c   = 1'b0;
        t   = 1'b0;
        nc  = 1'b0;
        for (int i = 1; i < WIDTH; i++) begin
            row = {{WIDTH{1'b0}}, op_a_q & {WIDTH{op_b_q[i]}}} << i;
            c   = 1'b0;
            for (int j = 0; j < 2*WIDTH; j++) begin
                t      = acc[j] ^ row[j];
                nc     = (acc[j] & row[j]) | (c & t);
                acc[j] = t ^ c;
                c      = nc;
            end
        end
        mul_p = acc;
    end

    // Round-robin grant: a tie goes to whoever was not served last
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state_q == IDLE) && req0_valid && (grant == 1'b0);
    assign req1_ready = (state_q == IDLE) && req1_valid && (grant == 1'b1);
    assign rsp0_valid = (state_q == RESP) && (owner_q == 1'b0);
    assign rsp1_valid = (state_q == RESP) && (owner_q == 1'b1);
    assign rsp0_p     = rsp0_valid ? p_q : '0;
    assign rsp1_p     = rsp1_valid ? p_q : '0;
    assign rsp_hs     = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);
    assign busy       = (state_q != IDLE);
    assign done_cnt   = done_cnt_q;

    // Next-state: accept in IDLE, count out CALC, hold the response until its owner takes it
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        p_d          = p_q;
        owner_d      = owner_q;
        calc_cnt_d   = calc_cnt_q;
        done_cnt_d   = done_cnt_q;
        case (state_q)
            IDLE: begin
                if (req0_ready) begin
                    op_a_d     = req0_a;
                    op_b_d     = req0_b;
                    owner_d    = 1'b0;
                    calc_cnt_d = '0;
                    state_d    = CALC;
                end else if (req1_ready) begin
                    op_a_d     = req1_a;
                    op_b_d     = req1_b;
                    owner_d    = 1'b1;
                    calc_cnt_d = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                calc_cnt_d = calc_cnt_q + 2'd1;
                if (calc_cnt_q == CALC_LAST) begin
                    p_d     = mul_p;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                    done_cnt_d   = done_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any in-flight transaction and re-arms requester 0 for the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            p_q          <= '0;
            owner_q      <= 1'b0;
            calc_cnt_q   <= '0;
            done_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            p_q          <= p_d;
            owner_q      <= owner_d;
            calc_cnt_q   <= calc_cnt_d;
            done_cnt_q   <= done_cnt_d;
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - directed checks of mult_share_arbiter at CALC_CYCLES 1 and 3
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       r0v, r0r, r1v, r1r, s0v, s0r, s1v, s1r, bsy;
    logic [3:0] r0a, r0b, r1a, r1b;
    logic [7:0] s0p, s1p, dcnt;

    logic       x0v, x0r, x1v, x1r, xs0v, xs0r, xs1v, xs1r, xbsy;
    logic [3:0] x0a, x0b, x1a, x1b;
    logic [7:0] xs0p, xs1p, xdcnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_share_arbiter #(.WIDTH(4), .CALC_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .rsp0_valid(s0v), .rsp0_ready(s0r), .rsp0_p(s0p),
        .rsp1_valid(s1v), .rsp1_ready(s1r), .rsp1_p(s1p),
        .busy(bsy), .done_cnt(dcnt)
    );

    mult_share_arbiter #(.WIDTH(4), .CALC_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(x0v), .req0_ready(x0r), .req0_a(x0a), .req0_b(x0b),
        .req1_valid(x1v), .req1_ready(x1r), .req1_a(x1a), .req1_b(x1b),
        .rsp0_valid(xs0v), .rsp0_ready(xs0r), .rsp0_p(xs0p),
        .rsp1_valid(xs1v), .rsp1_ready(xs1r), .rsp1_p(xs1p),
        .busy(xbsy), .done_cnt(xdcnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic cur_valid(input int sel);
        case (sel)
            0:       return s0v;
            1:       return s1v;
            2:       return xs0v;
            default: return xs1v;
        endcase
    endfunction

    // Called at the negedge after the accept edge; lat counts edges including the accept edge
    task automatic wait_valid(input int sel, output int lat);
        lat = 1;
        @(negedge clk);
        while (!cur_valid(sel) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!cur_valid(sel)) check("wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int lat;
    int ng;
    int cyc;
    int last;
    int k;

    initial begin
        r0v = 0; r1v = 0; s0r = 0; s1r = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
        x0v = 0; x1v = 0; xs0r = 0; xs1r = 0; x0a = 0; x0b = 0; x1a = 0; x1b = 0;

        // Reset state
        do_reset();
        check("rst_busy", bsy, 0);
        check("rst_done", dcnt, 0);
        check("rst_s0v", s0v, 0);
        check("rst_s1v", s1v, 0);
        check("rst_s0p", s0p, 0);
        check("rst_s1p", s1p, 0);
        check("rst_r0r", r0r, 0);

        // Single requester 0: 3*5, rsp_ready already high has no early effect
        s0r = 1; s1r = 1;
        r0v = 1; r0a = 4'd3; r0b = 4'd5;
        #1;
        check("t1_r0r", r0r, 1);
        check("t1_r1r", r1r, 0);
        @(posedge clk);
        #1;
        r0v = 0;
        check("t1_busy_calc", bsy, 1);
        check("t1_done_calc", dcnt, 0);
        wait_valid(0, lat);
        check("t1_lat", lat, 2);
        check("t1_p", s0p, 8'h0F);
        check("t1_s1v", s1v, 0);
        @(posedge clk);
        @(negedge clk);
        s0r = 0; s1r = 0;
        check("t1_done", dcnt, 1);
        check("t1_busy_after", bsy, 0);
        check("t1_s0v_after", s0v, 0);

        // Both valid continuously, immediate acks: strict alternation, one grant per 3 cycles
        do_reset();
        s0r = 1; s1r = 1;
        r0v = 1; r0a = 4'd15; r0b = 4'd15;
        r1v = 1; r1a = 4'd7;  r1b = 4'd9;
        ng = 0; cyc = 0; last = 0;
        while (ng < 8 && cyc < 60) begin
            #1;
            if (s0v) check("t2_p0", s0p, 8'hE1);
            if (s1v) check("t2_p1", s1p, 8'h3F);
            if (r0r || r1r) begin
                check("t2_one_ready", {31'd0, r0r & r1r}, 0);
                check("t2_grant", {31'd0, r1r}, ng % 2);
                if (ng > 0) check("t2_period", cyc - last, 3);
                last = cyc;
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        r0v = 0; r1v = 0;
        check("t2_grants", ng, 8);
        while (bsy && cyc < 80) begin
            #1;
            if (s1v) check("t2_p1_last", s1p, 8'h3F);
            @(negedge clk);
            cyc++;
        end
        s0r = 0; s1r = 0;
        check("t2_idle", bsy, 0);
        check("t2_done", dcnt, 8);

        // Response backpressure on requester 1: 12*10 held while both requests wait
        r1v = 1; r1a = 4'd12; r1b = 4'd10;
        #1;
        check("t3_r1r", r1r, 1);
        @(posedge clk);
        #1;
        r1v = 0;
        wait_valid(1, lat);
        check("t3_lat", lat, 2);
        r0v = 1; r0a = 4'd1; r0b = 4'd1;
        r1v = 1; r1a = 4'd2; r1b = 4'd2;
        s0r = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_s1v", s1v, 1);
            check("t3_s1p", s1p, 8'h78);
            check("t3_s0v", s0v, 0);
            check("t3_r0r", r0r, 0);
            check("t3_r1r_hold", r1r, 0);
            check("t3_busy", bsy, 1);
            @(negedge clk);
        end
        r0v = 0; r1v = 0; s0r = 0;
        s1r = 1;
        @(posedge clk);
        @(negedge clk);
        s1r = 0;
        check("t3_idle", bsy, 0);
        check("t3_s1v_after", s1v, 0);
        check("t3_done", dcnt, 9);

        // Reset during CALC of 9*9 discards it; then 2*0
        r0v = 1; r0a = 4'd9; r0b = 4'd9;
        s0r = 1;
        @(posedge clk);
        #1;
        r0v = 0;
        check("t4_in_calc", bsy, 1);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        check("t4_s0v", s0v, 0);
        check("t4_busy", bsy, 0);
        check("t4_done", dcnt, 0);
        @(negedge clk);
        check("t4_s0v_later", s0v, 0);
        s0r = 0;
        r0v = 1; r0a = 4'd2; r0b = 4'd0;
        #1;
        check("t4_r0r", r0r, 1);
        @(posedge clk);
        #1;
        r0v = 0;
        wait_valid(0, lat);
        check("t4_p", s0p, 8'h00);
        s0r = 1;
        @(posedge clk);
        @(negedge clk);
        s0r = 0;
        check("t4_done_after", dcnt, 1);

        // CALC_CYCLES=3: exhaustive sweep alternating requesters, done_cnt wraps
        do_reset();
        for (k = 0; k < 256; k++) begin
            if (k % 2 == 0) begin
                x0v = 1; x0a = 4'(k >> 4); x0b = 4'(k);
            end else begin
                x1v = 1; x1a = 4'(k >> 4); x1b = 4'(k);
            end
            #1;
            check("t5_ready", (k % 2 == 0) ? x0r : x1r, 1);
            @(posedge clk);
            #1;
            x0v = 0; x1v = 0;
            wait_valid(2 + (k % 2), lat);
            check("t5_lat", lat, 4);
            check("t5_p", (k % 2 == 0) ? xs0p : xs1p, (k >> 4) * (k % 16));
            xs0r = 1; xs1r = 1;
            @(posedge clk);
            @(negedge clk);
            xs0r = 0; xs1r = 0;
            if (k == 254) check("t5_done_254", xdcnt, 255);
        end
        check("t5_done_wrap", xdcnt, 0);
        check("t5_idle", xbsy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
